// File: rtl/div_issue_queue.sv
// Request FIFO and credit-throttled issue stage in front of the non-restoring divider.
// Optional macro DIV_ZERO_TRAP_EN drops zero-divisor requests at the FIFO head and pulses err_zero.
module div_issue_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [15:0]              in_divisor,
    input  logic [31:0]              in_dividend,
    output logic                     div_valid_in,
    output logic                     div_mode,
    output logic [15:0]              div_divisor,
    output logic [31:0]              div_dividend,
    input  logic                     div_valid_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               inflight,
    output logic                     err_zero
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [3:0]       MAX_C   = 4'(MAX_INFLIGHT);

    logic              mode_mem [DEPTH];
    logic [15:0]       dvs_mem  [DEPTH];
    logic [31:0]       dvd_mem  [DEPTH];

    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        inflight_q, inflight_d;
    logic              valid_q, valid_d;
    logic              mode_q, mode_d;
    logic [15:0]       dvs_q, dvs_d;
    logic [31:0]       dvd_q, dvd_d;
    logic              err_q, err_d;

    logic              push, pop, issue, drop, head_valid, credit_ret;

    assign in_ready     = (count_q < DEPTH_C);
    assign push         = in_valid && in_ready;
    assign head_valid   = (count_q != '0);
    assign credit_ret   = div_valid_out && (inflight_q != '0);

`ifdef DIV_ZERO_TRAP_EN
    assign drop = head_valid && (dvs_mem[rd_q] == '0);
`else
    assign drop = 1'b0;
`endif

    // Credit test uses the registered count, so a same-cycle return cannot enable an issue.
    assign issue = head_valid && !drop && (inflight_q < MAX_C);
    assign pop   = issue || drop;

    always_comb begin
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        valid_d    = issue;
        err_d      = drop;
        mode_d     = mode_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;

        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        inflight_d = inflight_q + 4'(issue) - 4'(credit_ret);

        if (issue) begin
            mode_d = mode_mem[rd_q];
            dvs_d  = dvs_mem[rd_q];
            dvd_d  = dvd_mem[rd_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mode_mem[wr_q] <= in_mode;
            dvs_mem[wr_q]  <= in_divisor;
            dvd_mem[wr_q]  <= in_dividend;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            mode_q     <= 1'b0;
            dvs_q      <= '0;
            dvd_q      <= '0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            mode_q     <= mode_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
        end
    end

    assign count        = count_q;
    assign inflight     = inflight_q;
    assign div_valid_in = valid_q;
    assign div_mode     = mode_q;
    assign div_divisor  = dvs_q;
    assign div_dividend = dvd_q;
    assign err_zero     = err_q;

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: queue-based reference model, vector table, corner sequences, random traffic.
module tb_div_issue_queue;

    localparam int DEPTH = 4;
    localparam int MAXI  = 2;
`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [15:0] in_divisor = '0;
    logic [31:0] in_dividend = '0;
    logic        div_valid_in;
    logic        div_mode;
    logic [15:0] div_divisor;
    logic [31:0] div_dividend;
    logic        div_valid_out = 1'b0;
    logic [2:0]  count;
    logic [3:0]  inflight;
    logic        err_zero;

    always #5 clk = ~clk;

    div_issue_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_divisor(in_divisor), .in_dividend(in_dividend),
        .div_valid_in(div_valid_in), .div_mode(div_mode),
        .div_divisor(div_divisor), .div_dividend(div_dividend),
        .div_valid_out(div_valid_out),
        .count(count), .inflight(inflight), .err_zero(err_zero)
    );

    typedef struct {
        logic        mode;
        logic [15:0] dvs;
        logic [31:0] dvd;
    } req_t;

    // Reference model: pending requests as a queue plus the visible output state.
    req_t        mq[$];
    logic [31:0] issued[$];
    int          m_infl = 0;
    logic        m_valid = 0, m_mode = 0, m_err = 0;
    logic [15:0] m_dvs = '0;
    logic [31:0] m_dvd = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit   rdy = (mq.size() < DEPTH);
        bit   iss = 0, drp = 0;
        req_t r;
        if (!reset) begin
            mq.delete();
            m_infl = 0; m_valid = 0; m_err = 0; m_mode = 0; m_dvs = '0; m_dvd = '0;
            return;
        end
        if (mq.size() > 0) begin
            if (TRAP && mq[0].dvs == 16'd0) drp = 1;
            else if (m_infl < MAXI) iss = 1;
        end
        m_valid = iss;
        m_err   = drp;
        if (iss) begin
            m_mode = mq[0].mode; m_dvs = mq[0].dvs; m_dvd = mq[0].dvd;
            issued.push_back(mq[0].dvd);
        end
        m_infl = m_infl + (iss ? 1 : 0) - ((div_valid_out && m_infl > 0) ? 1 : 0);
        if (iss || drp) void'(mq.pop_front());
        if (in_valid && rdy) begin
            r.mode = in_mode; r.dvs = in_divisor; r.dvd = in_dividend;
            mq.push_back(r);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("count",    64'(count),        64'(mq.size()));
        chk("inflight", 64'(inflight),     64'(m_infl));
        chk("in_ready", 64'(in_ready),     64'(mq.size() < DEPTH));
        chk("valid_in", 64'(div_valid_in), 64'(m_valid));
        chk("mode",     64'(div_mode),     64'(m_mode));
        chk("divisor",  64'(div_divisor),  64'(m_dvs));
        chk("dividend", 64'(div_dividend), 64'(m_dvd));
        chk("err_zero", 64'(err_zero),     64'(m_err));
    endtask

    task automatic drive(input logic v, input logic m, input logic [15:0] s,
                         input logic [31:0] d, input logic ret);
        in_valid = v; in_mode = m; in_divisor = s; in_dividend = d; div_valid_out = ret;
    endtask

    typedef struct {
        logic        vld;
        logic        mode;
        logic [15:0] dvs;
        logic [31:0] dvd;
        logic        ret;
        int          e_cnt;
        int          e_infl;
        logic        e_v;
        logic [31:0] e_dvd;
        logic        e_rdy;
    } vec_t;

    localparam logic [31:0] A = 32'd537133248;

    vec_t tbl[$];

    initial begin
        // Basic issue and credit return, then backpressure, full queue and simultaneous events.
        tbl.push_back('{1, 1, 16'd5, 32'd21, 0, 1, 0, 0, 32'd0, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  0, 0, 1, 1, 32'd21, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  0, 0, 1, 0, 32'd21, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  1, 0, 0, 0, 32'd21, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  1, 0, 0, 0, 32'd21, 1});
        tbl.push_back('{1, 0, 16'd3, A+0,    0, 1, 0, 0, 32'd21, 1});
        tbl.push_back('{1, 0, 16'd3, A+1,    0, 1, 1, 1, A+0, 1});
        tbl.push_back('{1, 0, 16'd3, A+2,    0, 1, 2, 1, A+1, 1});
        tbl.push_back('{1, 0, 16'd3, A+3,    0, 2, 2, 0, A+1, 1});
        tbl.push_back('{1, 0, 16'd3, A+4,    0, 3, 2, 0, A+1, 1});
        tbl.push_back('{1, 0, 16'd3, A+5,    0, 4, 2, 0, A+1, 0});
        tbl.push_back('{1, 0, 16'd3, A+99,   0, 4, 2, 0, A+1, 0});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  1, 4, 1, 0, A+1, 0});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  0, 3, 2, 1, A+2, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  1, 3, 1, 0, A+2, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  0, 2, 2, 1, A+3, 1});
        tbl.push_back('{1, 0, 16'd7, 32'd100, 1, 3, 1, 0, A+3, 1});
        tbl.push_back('{1, 0, 16'd9, 32'd200, 1, 3, 1, 1, A+4, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  1, 2, 1, 1, A+5, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  1, 1, 1, 1, 32'd100, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  1, 0, 1, 1, 32'd200, 1});
        tbl.push_back('{0, 0, 16'd0, 32'd0,  1, 0, 0, 0, 32'd200, 1});

        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        reset = 1'b1;
        cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].vld, tbl[i].mode, tbl[i].dvs, tbl[i].dvd, tbl[i].ret);
            cycle();
            chk($sformatf("vec%0d.count", i),    64'(count),        64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.inflight", i), 64'(inflight),     64'(tbl[i].e_infl));
            chk($sformatf("vec%0d.valid", i),    64'(div_valid_in), 64'(tbl[i].e_v));
            chk($sformatf("vec%0d.dividend", i), 64'(div_dividend), 64'(tbl[i].e_dvd));
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready),     64'(tbl[i].e_rdy));
        end

        // Zero divisor followed by a normal request.
        drive(1, 0, 16'd0, 32'd50, 0); cycle();
        drive(1, 0, 16'd5, 32'd60, 0); cycle();
        if (TRAP) begin
            chk("dz.err_pulse", 64'(err_zero), 64'd1);
            chk("dz.no_issue",  64'(div_valid_in), 64'd0);
        end else begin
            chk("dz.err_tied",  64'(err_zero), 64'd0);
            chk("dz.issue0",    64'(div_dividend), 64'd50);
        end
        drive(0, 0, 16'd0, 32'd0, 0); cycle();
        chk("dz.err_after",  64'(err_zero), 64'd0);
        chk("dz.issue5",     64'(div_dividend), 64'd60);
        chk("dz.inflight",   64'(inflight), TRAP ? 64'd1 : 64'd2);
        drive(0, 0, 16'd0, 32'd0, 1); cycle(); cycle(); cycle();

        // Reset while requests are queued and in flight.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 16'd11, 32'(1000 + i), 0); cycle();
        end
        chk("rst.pre_count", 64'(count), 64'd3);
        chk("rst.pre_infl",  64'(inflight), 64'd2);
        drive(0, 0, 16'd0, 32'd0, 0);
        reset = 1'b0; cycle();
        reset = 1'b1;
        chk("rst.count",    64'(count), 64'd0);
        chk("rst.inflight", 64'(inflight), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.valid",    64'(div_valid_in), 64'd0);
        drive(0, 0, 16'd0, 32'd0, 1); cycle();
        chk("rst.late_ret", 64'(inflight), 64'd0);
        cycle();
        chk("rst.late_ret2", 64'(inflight), 64'd0);

        // Stream across the pointer wrap with an immediate reply every cycle.
        begin
            logic [31:0] sent[$];
            int n = 0;
            int budget = 0;
            issued.delete();
            while ((n < 3 * DEPTH || issued.size() < 3 * DEPTH) && budget < 100) begin
                if (n < 3 * DEPTH) begin
                    drive(1, n[0], 16'(n + 1), 32'(5000 + n), 1);
                    if (mq.size() < DEPTH) begin
                        sent.push_back(32'(5000 + n));
                        n++;
                    end
                end else begin
                    drive(0, 0, 16'd0, 32'd0, 1);
                end
                cycle();
                budget++;
            end
            chk("wrap.issued", 64'(issued.size()), 64'(3 * DEPTH));
            for (int i = 0; i < sent.size() && i < issued.size(); i++)
                chk($sformatf("wrap.order%0d", i), 64'(issued[i]), 64'(sent[i]));
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom),
                  $urandom, $urandom_range(0, 9) < 4);
            reset = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset = 1'b1;
        drive(0, 0, 16'd0, 32'd0, 0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
